// File: rtl/execute_stage.sv
// ============================================================================
// Module      : execute_stage
// Description : Pipeline execute stage: ALU, branch resolution and the EX/MEM
//               register with wrong-path squash and memory-stall hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC2_IDEX,
  input  logic [15:0] Rd1_IDEX,
  input  logic [15:0] Rd2_IDEX,
  input  logic [15:0] Imm_IDEX,
  input  logic [4:0]  ALUOp_IDEX,
  input  logic [1:0]  ALUF_IDEX,
  input  logic        ALUSrc_IDEX,
  input  logic        Branch_IDEX,
  input  logic        Dump_IDEX,
  input  logic        MemtoReg_IDEX,
  input  logic        MemWrite_IDEX,
  input  logic        MemRead_IDEX,
  input  logic        RegWrite_IDEX,
  input  logic [2:0]  WrR_IDEX,
  input  logic        stall_MEM,
  output logic [15:0] ALURes_EXMEM,
  output logic [15:0] Rd2_EXMEM,
  output logic [15:0] BrTarget_EXMEM,
  output logic [2:0]  WrR_EXMEM,
  output logic        RegWrite_EXMEM,
  output logic        MemWrite_EXMEM,
  output logic        MemRead_EXMEM,
  output logic        MemtoReg_EXMEM,
  output logic        Dump_EXMEM,
  output logic        takeBranch_EXMEM,
  output logic        err
);

  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [3:0]  w_amt;
  logic [4:0]  w_inv_amt;
  logic [16:0] w_sum;
  logic [15:0] w_rev;
  logic [15:0] w_alu_res;
  logic        w_illegal;
  logic        w_cond;
  logic        w_squash;
  logic [15:0] w_br_target;

  assign w_a         = Rd1_IDEX;
  assign w_b         = ALUSrc_IDEX ? Imm_IDEX : Rd2_IDEX;
  assign w_amt       = w_b[3:0];
  // Complementary shift for rotates; an amount of 0 shifts by 16, yielding 0.
  assign w_inv_amt   = 5'd16 - {1'b0, w_amt};
  assign w_sum       = {1'b0, w_a} + {1'b0, w_b};
  assign w_br_target = PC2_IDEX + Imm_IDEX;
  assign w_illegal   = ALUOp_IDEX[4];
  // The instruction behind a taken branch is wrong-path.
  assign w_squash    = takeBranch_EXMEM;

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < 16; i++) begin
      w_rev[i] = w_a[15-i];
    end
  end

  always_comb begin
    w_alu_res = '0;
    case (ALUOp_IDEX)
      5'h00:   w_alu_res = w_sum[15:0];
      5'h01:   w_alu_res = w_b - w_a;
      5'h02:   w_alu_res = w_a ^ w_b;
      5'h03:   w_alu_res = w_a & ~w_b;
      5'h04:   w_alu_res = (w_a << w_amt) | (w_a >> w_inv_amt);
      5'h05:   w_alu_res = w_a << w_amt;
      5'h06:   w_alu_res = (w_a >> w_amt) | (w_a << w_inv_amt);
      5'h07:   w_alu_res = w_a >> w_amt;
      5'h08:   w_alu_res = {15'd0, (w_a == w_b)};
      5'h09:   w_alu_res = {15'd0, ($signed(w_a) <  $signed(w_b))};
      5'h0A:   w_alu_res = {15'd0, ($signed(w_a) <= $signed(w_b))};
      5'h0B:   w_alu_res = {15'd0, w_sum[16]};
      5'h0C:   w_alu_res = w_rev;
      5'h0D:   w_alu_res = w_b;
      5'h0E:   w_alu_res = {w_a[7:0], w_b[7:0]};
      5'h0F:   w_alu_res = PC2_IDEX;
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (ALUF_IDEX)
      2'b00:   w_cond = (w_a == 16'h0000);
      2'b01:   w_cond = (w_a != 16'h0000);
      2'b10:   w_cond = w_a[15];
      default: w_cond = ~w_a[15];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALURes_EXMEM     <= '0;
      Rd2_EXMEM        <= '0;
      BrTarget_EXMEM   <= '0;
      WrR_EXMEM        <= '0;
      RegWrite_EXMEM   <= 1'b0;
      MemWrite_EXMEM   <= 1'b0;
      MemRead_EXMEM    <= 1'b0;
      MemtoReg_EXMEM   <= 1'b0;
      Dump_EXMEM       <= 1'b0;
      takeBranch_EXMEM <= 1'b0;
      err              <= 1'b0;
    end else if (!stall_MEM) begin
      ALURes_EXMEM     <= w_alu_res;
      Rd2_EXMEM        <= Rd2_IDEX;
      BrTarget_EXMEM   <= w_br_target;
      WrR_EXMEM        <= WrR_IDEX;
      MemtoReg_EXMEM   <= MemtoReg_IDEX;
      RegWrite_EXMEM   <= RegWrite_IDEX & ~w_squash;
      MemWrite_EXMEM   <= MemWrite_IDEX & ~w_squash;
      MemRead_EXMEM    <= MemRead_IDEX & ~w_squash;
      Dump_EXMEM       <= Dump_IDEX & ~w_squash;
      takeBranch_EXMEM <= Branch_IDEX & w_cond & ~w_squash;
      err              <= w_illegal & ~w_squash;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module      : tb_execute_stage
// Description : Scoreboard bench for execute_stage using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic [15:0] PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX;
  logic [4:0]  ALUOp_IDEX;
  logic [1:0]  ALUF_IDEX;
  logic        ALUSrc_IDEX, Branch_IDEX, Dump_IDEX, MemtoReg_IDEX;
  logic        MemWrite_IDEX, MemRead_IDEX, RegWrite_IDEX;
  logic [2:0]  WrR_IDEX;
  logic        stall_MEM;
  logic [15:0] ALURes_EXMEM, Rd2_EXMEM, BrTarget_EXMEM;
  logic [2:0]  WrR_EXMEM;
  logic        RegWrite_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM;
  logic        Dump_EXMEM, takeBranch_EXMEM, err;

  // ctl bit order: {RegWrite, MemWrite, MemRead, MemtoReg, Dump, takeBranch, err}
  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] rd2;
    logic [15:0] br;
    logic [2:0]  wrr;
    logic [6:0]  ctl;
  } exp_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .PC2_IDEX(PC2_IDEX), .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX), .Imm_IDEX(Imm_IDEX),
    .ALUOp_IDEX(ALUOp_IDEX), .ALUF_IDEX(ALUF_IDEX), .ALUSrc_IDEX(ALUSrc_IDEX),
    .Branch_IDEX(Branch_IDEX), .Dump_IDEX(Dump_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
    .MemWrite_IDEX(MemWrite_IDEX), .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
    .WrR_IDEX(WrR_IDEX), .stall_MEM(stall_MEM),
    .ALURes_EXMEM(ALURes_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .BrTarget_EXMEM(BrTarget_EXMEM),
    .WrR_EXMEM(WrR_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM),
    .MemRead_EXMEM(MemRead_EXMEM), .MemtoReg_EXMEM(MemtoReg_EXMEM), .Dump_EXMEM(Dump_EXMEM),
    .takeBranch_EXMEM(takeBranch_EXMEM), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every edge presents a new EX/MEM value; compare it against the oldest expectation.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        a = '{ALURes_EXMEM, Rd2_EXMEM, BrTarget_EXMEM, WrR_EXMEM,
               {RegWrite_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, MemtoReg_EXMEM,
                Dump_EXMEM, takeBranch_EXMEM, err}};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL exmem#%0d: got alu=%h rd2=%h br=%h wrr=%0d ctl=%b, expected alu=%h rd2=%h br=%h wrr=%0d ctl=%b",
                   checks, a.alu, a.rd2, a.br, a.wrr, a.ctl, e.alu, e.rd2, e.br, e.wrr, e.ctl);
        end
      end
    end
  end

  task automatic clr();
    PC2_IDEX = '0; Rd1_IDEX = '0; Rd2_IDEX = '0; Imm_IDEX = '0;
    ALUOp_IDEX = '0; ALUF_IDEX = '0; ALUSrc_IDEX = 1'b0; Branch_IDEX = 1'b0;
    Dump_IDEX = 1'b0; MemtoReg_IDEX = 1'b0; MemWrite_IDEX = 1'b0; MemRead_IDEX = 1'b0;
    RegWrite_IDEX = 1'b0; WrR_IDEX = '0; stall_MEM = 1'b0; rst = 1'b0;
  endtask

  // Queue the expected EX/MEM contents for the coming edge, then let the edge happen.
  task automatic issue(input logic [15:0] alu, input logic [15:0] rd2, input logic [15:0] br,
                       input logic [2:0] wrr, input logic [6:0] ctl);
    q_exp.push_back('{alu, rd2, br, wrr, ctl});
    @(posedge clk);
    #2;
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input logic src);
    clr();
    ALUOp_IDEX = op; Rd1_IDEX = a; ALUSrc_IDEX = src;
    if (src) Imm_IDEX = b; else Rd2_IDEX = b;
  endtask

  initial begin
    // Reset while stalled with live inputs
    clr(); rst = 1'b1; stall_MEM = 1'b1; Rd1_IDEX = 16'h1234; RegWrite_IDEX = 1'b1;
    issue(16'h0000, 16'h0000, 16'h0000, 3'd0, 7'b0000000);

    // ADD overflow wraps
    alu_op(5'h00, 16'h7FFF, 16'h0001, 1'b1); Rd2_IDEX = 16'hAAAA; RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd3;
    issue(16'h8000, 16'hAAAA, 16'h0001, 3'd3, 7'b1000000);
    alu_op(5'h01, 16'h0005, 16'h0003, 1'b0); MemWrite_IDEX = 1'b1;
    issue(16'hFFFE, 16'h0003, 16'h0000, 3'd0, 7'b0100000);
    alu_op(5'h02, 16'hF0F0, 16'hFF00, 1'b0); MemRead_IDEX = 1'b1; MemtoReg_IDEX = 1'b1;
    issue(16'h0FF0, 16'hFF00, 16'h0000, 3'd0, 7'b0011000);
    alu_op(5'h03, 16'hF0F0, 16'hFF00, 1'b0); Dump_IDEX = 1'b1;
    issue(16'h00F0, 16'hFF00, 16'h0000, 3'd0, 7'b0000100);

    // Shifts and rotates
    alu_op(5'h04, 16'h8001, 16'h0001, 1'b1); issue(16'h0003, 16'h0000, 16'h0001, 3'd0, 7'b0);
    alu_op(5'h05, 16'h8001, 16'h0001, 1'b1); issue(16'h0002, 16'h0000, 16'h0001, 3'd0, 7'b0);
    alu_op(5'h06, 16'h8001, 16'h0001, 1'b1); issue(16'hC000, 16'h0000, 16'h0001, 3'd0, 7'b0);
    alu_op(5'h07, 16'h8001, 16'h0001, 1'b1); issue(16'h4000, 16'h0000, 16'h0001, 3'd0, 7'b0);
    alu_op(5'h05, 16'h8001, 16'h0010, 1'b1); issue(16'h8001, 16'h0000, 16'h0010, 3'd0, 7'b0);

    // Set operations with A = -1, B = 1
    alu_op(5'h09, 16'hFFFF, 16'h0001, 1'b1); issue(16'h0001, 16'h0000, 16'h0001, 3'd0, 7'b0);
    alu_op(5'h0A, 16'hFFFF, 16'h0001, 1'b1); issue(16'h0001, 16'h0000, 16'h0001, 3'd0, 7'b0);
    alu_op(5'h08, 16'hFFFF, 16'h0001, 1'b1); issue(16'h0000, 16'h0000, 16'h0001, 3'd0, 7'b0);
    alu_op(5'h0B, 16'hFFFF, 16'h0001, 1'b1); issue(16'h0001, 16'h0000, 16'h0001, 3'd0, 7'b0);

    alu_op(5'h0C, 16'h0001, 16'h0000, 1'b0); issue(16'h8000, 16'h0000, 16'h0000, 3'd0, 7'b0);
    alu_op(5'h0D, 16'h0000, 16'hBEEF, 1'b0); issue(16'hBEEF, 16'hBEEF, 16'h0000, 3'd0, 7'b0);
    alu_op(5'h0E, 16'h12AB, 16'h00CD, 1'b1); issue(16'hABCD, 16'h0000, 16'h00CD, 3'd0, 7'b0);
    alu_op(5'h0F, 16'h0000, 16'h0000, 1'b0); PC2_IDEX = 16'h4321;
    issue(16'h4321, 16'h0000, 16'h4321, 3'd0, 7'b0);

    // Illegal opcodes flag err only
    alu_op(5'h15, 16'h1111, 16'h2222, 1'b0); RegWrite_IDEX = 1'b1;
    issue(16'h0000, 16'h2222, 16'h0000, 3'd0, 7'b1000001);
    alu_op(5'h1F, 16'h1111, 16'h0000, 1'b0);
    issue(16'h0000, 16'h0000, 16'h0000, 3'd0, 7'b0000001);

    // Taken branch, then wrong-path instruction is squashed
    alu_op(5'h00, 16'h0000, 16'h0000, 1'b0); Branch_IDEX = 1'b1; PC2_IDEX = 16'h0010; Imm_IDEX = 16'hFFFC;
    issue(16'h0000, 16'h0000, 16'h000C, 3'd0, 7'b0000010);
    alu_op(5'h00, 16'h0005, 16'h0001, 1'b0); RegWrite_IDEX = 1'b1; MemWrite_IDEX = 1'b1; WrR_IDEX = 3'd5;
    issue(16'h0006, 16'h0001, 16'h0000, 3'd5, 7'b0000000);
    alu_op(5'h0D, 16'h0005, 16'h0007, 1'b0); Branch_IDEX = 1'b1; ALUF_IDEX = 2'b01;
    issue(16'h0007, 16'h0007, 16'h0000, 3'd0, 7'b0000010);
    // Would-be taken branch on the wrong path must not take
    alu_op(5'h0F, 16'h8000, 16'h0000, 1'b0); Branch_IDEX = 1'b1; ALUF_IDEX = 2'b10;
    PC2_IDEX = 16'h0002; Imm_IDEX = 16'h0002;
    issue(16'h0002, 16'h0000, 16'h0004, 3'd0, 7'b0000000);
    alu_op(5'h00, 16'h8000, 16'h0000, 1'b0); Branch_IDEX = 1'b1; ALUF_IDEX = 2'b11; RegWrite_IDEX = 1'b1;
    issue(16'h8000, 16'h0000, 16'h0000, 3'd0, 7'b1000000);
    alu_op(5'h00, 16'h0001, 16'h0001, 1'b0); Branch_IDEX = 1'b1; ALUF_IDEX = 2'b11;
    issue(16'h0002, 16'h0001, 16'h0000, 3'd0, 7'b0000010);

    // Stall over a pending squash: hold three edges, squash lands on release
    for (int i = 1; i <= 3; i++) begin
      alu_op(5'h00, 16'h0100 * i[15:0], 16'h0000, 1'b0);
      RegWrite_IDEX = 1'b1; MemWrite_IDEX = 1'b1; stall_MEM = 1'b1;
      issue(16'h0002, 16'h0001, 16'h0000, 3'd0, 7'b0000010);
    end
    alu_op(5'h00, 16'h0400, 16'h0001, 1'b0); RegWrite_IDEX = 1'b1; MemWrite_IDEX = 1'b1; WrR_IDEX = 3'd6;
    issue(16'h0401, 16'h0001, 16'h0000, 3'd6, 7'b0000000);

    // Plain stall
    alu_op(5'h00, 16'h0010, 16'h0020, 1'b0); RegWrite_IDEX = 1'b1;
    issue(16'h0030, 16'h0020, 16'h0000, 3'd0, 7'b1000000);
    alu_op(5'h02, 16'hFFFF, 16'h0000, 1'b0); stall_MEM = 1'b1;
    issue(16'h0030, 16'h0020, 16'h0000, 3'd0, 7'b1000000);
    alu_op(5'h02, 16'hFFFF, 16'h00FF, 1'b0); RegWrite_IDEX = 1'b1;
    issue(16'hFF00, 16'h00FF, 16'h0000, 3'd0, 7'b1000000);

    // Reset while a branch is pending and memory stalls
    alu_op(5'h00, 16'h0000, 16'h0000, 1'b0); Branch_IDEX = 1'b1;
    issue(16'h0000, 16'h0000, 16'h0000, 3'd0, 7'b0000010);
    alu_op(5'h00, 16'h0005, 16'h0001, 1'b0); RegWrite_IDEX = 1'b1; rst = 1'b1; stall_MEM = 1'b1;
    issue(16'h0000, 16'h0000, 16'h0000, 3'd0, 7'b0000000);
    alu_op(5'h00, 16'h0005, 16'h0001, 1'b0); RegWrite_IDEX = 1'b1; MemWrite_IDEX = 1'b1;
    issue(16'h0006, 16'h0001, 16'h0000, 3'd0, 7'b1100000);

    clr();
    for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(posedge clk);
    #2;
    if (q_exp.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
